// File: rtl/assembler_feed_sequencer_if.sv
// Bundle between the feed sequencer, the editor BRAM read port and the assembler.
// The sequencer takes the slave side; the surrounding system (or bench) takes master.
interface assembler_feed_sequencer_if #(
    parameter int LINE_WIDTH = 64,
    parameter int NUM_LINES  = 256,
    parameter int NUM_PASSES = 2,
    parameter int CHAR_W     = 8
);
    localparam int COL_W  = $clog2(LINE_WIDTH);
    localparam int LN_W   = $clog2(NUM_LINES);
    localparam int ADDR_W = COL_W + LN_W;
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    logic              start_in;
    logic              abort_in;
    logic [LN_W-1:0]   first_line_in;
    logic [LN_W-1:0]   last_line_in;
    logic              line_done_in;
    logic [ADDR_W-1:0] addr_out;
    logic              rd_en_out;
    logic [CHAR_W-1:0] char_in;
    logic              new_line_out;
    logic              new_char_out;
    logic [CHAR_W-1:0] char_out;
    logic [COL_W-1:0]  col_out;
    logic [LN_W-1:0]   line_out;
    logic [PASS_W-1:0] pass_out;
    logic              busy_out;
    logic              done_out;
    logic              error_out;

    modport slave (
        input  start_in, abort_in, first_line_in, last_line_in, line_done_in, char_in,
        output addr_out, rd_en_out, new_line_out, new_char_out, char_out, col_out,
               line_out, pass_out, busy_out, done_out, error_out
    );

    modport master (
        output start_in, abort_in, first_line_in, last_line_in, line_done_in, char_in,
        input  addr_out, rd_en_out, new_line_out, new_char_out, char_out, col_out,
               line_out, pass_out, busy_out, done_out, error_out
    );
endinterface

// File: rtl/assembler_feed_sequencer.sv
// Multi-pass character-grid line streamer feeding the assembler from the editor BRAM.
// Optional FEED_NUL_TERMINATE_EN: a delivered NUL ends the current line early.
module assembler_feed_sequencer #(
    parameter int LINE_WIDTH   = 64,
    parameter int NUM_LINES    = 256,
    parameter int NUM_PASSES   = 2,
    parameter int READ_LATENCY = 2,
    parameter int CHAR_W       = 8
) (
    input  logic clk_in,
    input  logic rst_in,
    assembler_feed_sequencer_if.slave bus
);
    localparam int COL_W  = $clog2(LINE_WIDTH);
    localparam int LN_W   = $clog2(NUM_LINES);
    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int RL     = READ_LATENCY;

    typedef enum logic [2:0] {IDLE, NEW_LINE, SEND, DRAIN, ERROR} state_t;

    state_t               state;
    logic [LN_W-1:0]      first_q, last_q, line_q;
    logic [COL_W-1:0]     col_q;
    logic [PASS_W-1:0]    pass_q;
    // bit 0 is the read being issued this cycle; bit RL is the one whose data is on char_in
    logic [RL:0]          vld_pipe;
    logic [RL:1][COL_W-1:0] col_pipe;
    logic                 new_line_q, busy_q, done_q, error_q;

    logic inflight, nul_hit, deliver, squash_line, busy_state;

    // Tags still travelling towards char_in, excluding the one delivered this cycle.
    always_comb begin
        inflight = 1'b0;
        for (int i = 1; i < RL; i++) inflight = inflight | vld_pipe[i];
    end

`ifdef FEED_NUL_TERMINATE_EN
    assign nul_hit = vld_pipe[RL] && (bus.char_in == '0);
`else
    assign nul_hit = 1'b0;
`endif

    assign deliver     = vld_pipe[RL] && !nul_hit;
    assign squash_line = bus.line_done_in || nul_hit;
    assign busy_state  = (state == NEW_LINE) || (state == SEND) || (state == DRAIN);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            first_q    <= '0;
            last_q     <= '0;
            line_q     <= '0;
            col_q      <= '0;
            pass_q     <= '0;
            vld_pipe   <= '0;
            col_pipe   <= '0;
            new_line_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            new_line_q <= 1'b0;
            done_q     <= 1'b0;
            vld_pipe[RL:1] <= vld_pipe[RL-1:0];
            col_pipe[1]    <= col_q;
            for (int i = 2; i <= RL; i++) col_pipe[i] <= col_pipe[i-1];

            if (bus.start_in) begin
                first_q  <= bus.first_line_in;
                last_q   <= bus.last_line_in;
                line_q   <= bus.first_line_in;
                col_q    <= '0;
                pass_q   <= '0;
                vld_pipe <= '0;
                error_q  <= 1'b0;
                busy_q   <= 1'b1;
                // An inverted range completes immediately: busy and done share one cycle.
                if (bus.first_line_in > bus.last_line_in) begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end else begin
                    new_line_q <= 1'b1;
                    state      <= NEW_LINE;
                end
            end else if (bus.abort_in && busy_state) begin
                vld_pipe <= '0;
                error_q  <= 1'b1;
                busy_q   <= 1'b0;
                state    <= ERROR;
            end else begin
                case (state)
                    IDLE: busy_q <= 1'b0;
                    NEW_LINE: begin
                        vld_pipe[0] <= 1'b1;
                        state       <= SEND;
                    end
                    SEND: begin
                        if (squash_line) begin
                            vld_pipe <= '0;
                            state    <= DRAIN;
                        end else if (col_q == COL_W'(LINE_WIDTH - 1)) begin
                            vld_pipe[0] <= 1'b0;
                            state       <= DRAIN;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (squash_line) begin
                            vld_pipe <= '0;
                        end else if (!inflight) begin
                            if (line_q != last_q) begin
                                line_q     <= line_q + 1'b1;
                                col_q      <= '0;
                                new_line_q <= 1'b1;
                                state      <= NEW_LINE;
                            end else if (pass_q != PASS_W'(NUM_PASSES - 1)) begin
                                pass_q     <= pass_q + 1'b1;
                                line_q     <= first_q;
                                col_q      <= '0;
                                new_line_q <= 1'b1;
                                state      <= NEW_LINE;
                            end else begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                    ERROR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Character path is a pass-through of the BRAM data qualified by the aligned tag.
    assign bus.addr_out     = {line_q, col_q};
    assign bus.rd_en_out    = vld_pipe[0];
    assign bus.new_line_out = new_line_q;
    assign bus.new_char_out = deliver;
    assign bus.char_out     = deliver ? bus.char_in : '0;
    assign bus.col_out      = deliver ? col_pipe[RL] : '0;
    assign bus.line_out     = line_q;
    assign bus.pass_out     = pass_q;
    assign bus.busy_out     = busy_q;
    assign bus.done_out     = done_q;
    assign bus.error_out    = error_q;
endmodule

// File: tb/tb_assembler_feed_sequencer.sv
// Scoreboard bench for assembler_feed_sequencer: a default-latency instance plus a
// READ_LATENCY=3 instance used for early line termination.
module tb_assembler_feed_sequencer;
    localparam int LW  = 64;
    localparam int NL  = 256;
    localparam int NP  = 2;
    localparam int RL  = 2;
    localparam int RL3 = 3;
`ifdef FEED_NUL_TERMINATE_EN
    localparam logic [7:0] OFS = 8'h40;
`else
    localparam logic [7:0] OFS = 8'h00;
`endif

    typedef struct {
        int kind;  // 0 new_line, 1 char, 2 done
        int line;
        int pass;
        int col;
        int chr;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    ev_t  q[$];
    logic [7:0] mem [0:LW*NL-1];
    logic [7:0] rdp  [1:4];
    logic [7:0] rdp3 [1:4];

    always #5 clk = ~clk;

    assembler_feed_sequencer_if #(.LINE_WIDTH(LW), .NUM_LINES(NL), .NUM_PASSES(NP), .CHAR_W(8)) bus ();
    assembler_feed_sequencer_if #(.LINE_WIDTH(LW), .NUM_LINES(NL), .NUM_PASSES(NP), .CHAR_W(8)) bus3 ();

    assembler_feed_sequencer #(.LINE_WIDTH(LW), .NUM_LINES(NL), .NUM_PASSES(NP),
                               .READ_LATENCY(RL), .CHAR_W(8))
        u_dut (.clk_in(clk), .rst_in(rst), .bus(bus));
    assembler_feed_sequencer #(.LINE_WIDTH(LW), .NUM_LINES(NL), .NUM_PASSES(NP),
                               .READ_LATENCY(RL3), .CHAR_W(8))
        u_dut3 (.clk_in(clk), .rst_in(rst), .bus(bus3));

    // BRAM models: data for a read issued in cycle k is on char_in in cycle k+latency.
    always @(posedge clk) begin
        if (bus.rd_en_out) rdp[1] <= mem[bus.addr_out];
        if (bus3.rd_en_out) rdp3[1] <= mem[bus3.addr_out];
        for (int i = 2; i <= 4; i++) begin
            rdp[i]  <= rdp[i-1];
            rdp3[i] <= rdp3[i-1];
        end
    end
    assign bus.char_in  = rdp[RL];
    assign bus3.char_in = rdp3[RL3];

    task automatic fill_grid();
        for (int l = 0; l < NL; l++)
            for (int c = 0; c < LW; c++) mem[l*LW+c] = 8'(c) + OFS;
    endtask

    task automatic push_line(input int ln, input int ps, input int ncols);
        ev_t e;
        e.kind = 0; e.line = ln; e.pass = ps; e.col = 0; e.chr = 0;
        q.push_back(e);
        for (int c = 0; c < ncols; c++) begin
            e.kind = 1; e.col = c; e.chr = int'(mem[ln*LW+c]);
            q.push_back(e);
        end
    endtask

    task automatic push_done();
        ev_t e;
        e.kind = 2; e.line = 0; e.pass = 0; e.col = 0; e.chr = 0;
        q.push_back(e);
    endtask

    task automatic start_run(input int f, input int l);
        @(negedge clk);
        bus.first_line_in = 8'(f);
        bus.last_line_in  = 8'(l);
        bus.start_in      = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy_out, bus.done_out, bus.error_out} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status got=%b expected=000", {bus.busy_out, bus.done_out, bus.error_out});
        end
        checks++;
        if ({bus.new_line_out, bus.new_char_out, bus.rd_en_out} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b expected=000", {bus.new_line_out, bus.new_char_out, bus.rd_en_out});
        end
        checks++;
        if ({bus.addr_out, bus.char_out, bus.col_out, bus.line_out, bus.pass_out} !== '0) begin
            failures++;
            $display("FAIL reset_buses addr=%0h char=%0h col=%0d line=%0d pass=%0d expected all 0",
                     bus.addr_out, bus.char_out, bus.col_out, bus.line_out, bus.pass_out);
        end
        rst = 1'b0;
        @(negedge clk);
        bus.line_done_in = 1'b1;
        @(negedge clk);
        bus.line_done_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy_out, bus.rd_en_out, bus.new_line_out} !== 3'b000) begin
            failures++;
            $display("FAIL idle_line_done got=%b expected=000", {bus.busy_out, bus.rd_en_out, bus.new_line_out});
        end
    endtask

    task automatic test_full_scan();
        int cyc;
        fill_grid();
        push_line(0, 0, LW); push_line(1, 0, LW);
        push_line(0, 1, LW); push_line(1, 1, LW);
        push_done();
        start_run(0, 1);
        checks++;
        if (bus.busy_out !== 1'b1 || bus.error_out !== 1'b0) begin
            failures++;
            $display("FAIL full_busy got busy=%b err=%b expected busy=1 err=0", bus.busy_out, bus.error_out);
        end
        cyc = 1;
        while (!bus.done_out && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != NP*2*(1+LW+RL)+1) begin
            failures++;
            $display("FAIL full_latency got=%0d cycles expected=%0d", cyc, NP*2*(1+LW+RL)+1);
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL full_end got pending=%0d busy=%b expected pending=0 busy=0", q.size(), bus.busy_out);
        end
    endtask

    task automatic test_abort();
        int n;
        fill_grid();
        push_line(0, 0, LW); push_line(1, 0, LW); push_line(0, 1, 6);
        start_run(0, 1);
        n = 0;
        while (!(bus.new_char_out && bus.pass_out == 1 && bus.line_out == 0 && bus.col_out == 5) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            failures++;
            $display("FAIL abort_reach got timeout expected pass1 line0 col5");
        end
        bus.abort_in = 1'b1;
        @(negedge clk);
        bus.abort_in = 1'b0;
        checks++;
        if (bus.error_out !== 1'b1 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_flags got err=%b busy=%b expected err=1 busy=0", bus.error_out, bus.busy_out);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (q.size() != 0 || bus.error_out !== 1'b1 || bus.rd_en_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_sticky got pending=%0d err=%b rd=%b expected 0/1/0", q.size(), bus.error_out, bus.rd_en_out);
        end
        push_line(0, 0, LW); push_line(0, 1, LW); push_done();
        start_run(0, 0);
        checks++;
        if (bus.error_out !== 1'b0 || bus.busy_out !== 1'b1 || bus.pass_out !== 1'd0) begin
            failures++;
            $display("FAIL abort_restart got err=%b busy=%b pass=%0d expected 0/1/0", bus.error_out, bus.busy_out, bus.pass_out);
        end
        n = 0;
        while ((q.size() != 0 || bus.busy_out) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_rerun got pending=%0d busy=%b expected 0/0", q.size(), bus.busy_out);
        end
    endtask

    task automatic test_empty_range();
        push_done();
        start_run(5, 3);
        checks++;
        if ({bus.done_out, bus.busy_out, bus.new_line_out} !== 3'b110) begin
            failures++;
            $display("FAIL empty_first got done,busy,nl=%b expected=110", {bus.done_out, bus.busy_out, bus.new_line_out});
        end
        @(negedge clk);
        checks++;
        if ({bus.done_out, bus.busy_out, bus.rd_en_out} !== 3'b000 || q.size() != 0) begin
            failures++;
            $display("FAIL empty_after got done,busy,rd=%b pending=%0d expected 000/0",
                     {bus.done_out, bus.busy_out, bus.rd_en_out}, q.size());
        end
    endtask

    task automatic test_restart();
        int n;
        fill_grid();
        push_line(0, 0, LW); push_line(1, 0, LW); push_line(2, 0, 4);
        start_run(0, 3);
        n = 0;
        while (!(bus.new_char_out && bus.line_out == 2 && bus.col_out == 3) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        push_line(1, 0, LW); push_line(1, 1, LW); push_done();
        bus.first_line_in = 8'd1;
        bus.last_line_in  = 8'd1;
        bus.start_in      = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        checks++;
        if (bus.new_line_out !== 1'b1 || bus.line_out !== 8'd1 || bus.pass_out !== 1'd0) begin
            failures++;
            $display("FAIL restart_line got nl=%b line=%0d pass=%0d expected 1/1/0", bus.new_line_out, bus.line_out, bus.pass_out);
        end
        n = 0;
        while ((q.size() != 0 || bus.busy_out) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL restart_end got pending=%0d busy=%b expected 0/0", q.size(), bus.busy_out);
        end
    endtask

    task automatic test_line_done();
        int qb[$];
        int ld_cyc, e, c;
        bit nl_seen, done_seen;
        fill_grid();
        for (int i = 0; i <= 10; i++) qb.push_back(i);
        for (int i = 0; i < LW; i++) qb.push_back(i);
        ld_cyc = -1; nl_seen = 0; done_seen = 0;
        @(negedge clk);
        bus3.first_line_in = 8'd0;
        bus3.last_line_in  = 8'd0;
        bus3.start_in      = 1'b1;
        @(negedge clk);
        bus3.start_in = 1'b0;
        for (c = 0; c < 1000 && !done_seen; c++) begin
            bus3.line_done_in = 1'b0;
            if (bus3.new_char_out) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL ld_extra got col=%0d pass=%0d expected no char", bus3.col_out, bus3.pass_out);
                end else begin
                    e = qb.pop_front();
                    if (bus3.col_out !== 6'(e) || bus3.char_out !== 8'(e) + OFS) begin
                        failures++;
                        $display("FAIL ld_char got col=%0d chr=%0h expected col=%0d chr=%0h",
                                 bus3.col_out, bus3.char_out, e, 8'(e) + OFS);
                    end
                end
                if (bus3.pass_out == 0 && bus3.col_out == 10) begin
                    bus3.line_done_in = 1'b1;
                    ld_cyc = c;
                end
            end
            if (bus3.new_line_out && ld_cyc >= 0 && !nl_seen) begin
                nl_seen = 1;
                checks++;
                if (c - ld_cyc > 2 || bus3.pass_out !== 1'd1) begin
                    failures++;
                    $display("FAIL ld_next_line got gap=%0d pass=%0d expected gap<=2 pass=1", c - ld_cyc, bus3.pass_out);
                end
            end
            if (bus3.done_out) done_seen = 1;
            @(negedge clk);
        end
        bus3.line_done_in = 1'b0;
        checks++;
        if (!done_seen || !nl_seen || qb.size() != 0) begin
            failures++;
            $display("FAIL ld_end got done=%0d nl=%0d pending=%0d expected 1/1/0", done_seen, nl_seen, qb.size());
        end
    endtask

`ifdef FEED_NUL_TERMINATE_EN
    task automatic test_nul();
        int n;
        fill_grid();
        mem[0] = 8'h41; mem[1] = 8'h44; mem[2] = 8'h44; mem[3] = 8'h00;
        for (int p = 0; p < NP; p++) begin
            push_line(0, p, 3);
            push_line(1, p, LW);
        end
        push_done();
        start_run(0, 1);
        n = 0;
        while ((q.size() != 0 || bus.busy_out) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL nul_end got pending=%0d busy=%b expected 0/0", q.size(), bus.busy_out);
        end
    endtask
`endif

    initial begin
        ev_t mo, me;
        bus.start_in = 1'b0; bus.abort_in = 1'b0; bus.line_done_in = 1'b0;
        bus.first_line_in = '0; bus.last_line_in = '0;
        bus3.start_in = 1'b0; bus3.abort_in = 1'b0; bus3.line_done_in = 1'b0;
        bus3.first_line_in = '0; bus3.last_line_in = '0;
        fill_grid();
        // Scoreboard: every observed event on the main instance pops one expectation.
        fork
            forever begin
                @(negedge clk);
                if (!rst && (bus.new_line_out || bus.new_char_out || bus.done_out)) begin
                    mo.kind = bus.done_out ? 2 : (bus.new_char_out ? 1 : 0);
                    mo.line = (mo.kind == 2) ? 0 : int'(bus.line_out);
                    mo.pass = (mo.kind == 2) ? 0 : int'(bus.pass_out);
                    mo.col  = (mo.kind == 1) ? int'(bus.col_out) : 0;
                    mo.chr  = (mo.kind == 1) ? int'(bus.char_out) : 0;
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected got kind=%0d line=%0d pass=%0d col=%0d chr=%0h expected none",
                                 mo.kind, mo.line, mo.pass, mo.col, mo.chr);
                    end else begin
                        me = q.pop_front();
                        if (mo.kind != me.kind || mo.line != me.line || mo.pass != me.pass ||
                            mo.col != me.col || mo.chr != me.chr) begin
                            failures++;
                            $display("FAIL sb_event got kind=%0d line=%0d pass=%0d col=%0d chr=%0h expected kind=%0d line=%0d pass=%0d col=%0d chr=%0h",
                                     mo.kind, mo.line, mo.pass, mo.col, mo.chr,
                                     me.kind, me.line, me.pass, me.col, me.chr);
                        end
                    end
                end
            end
        join_none
        test_reset();
        test_full_scan();
        test_abort();
        test_empty_range();
        test_restart();
        test_line_done();
`ifdef FEED_NUL_TERMINATE_EN
        test_nul();
`endif
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/assembler_feed_sequencer.md
Name: assembler_feed_sequencer

Overview:
- Parametrised multi-pass line streamer. Walks a character-grid BRAM line by line and column by column, and presents each character to a downstream consumer (the assembler) with a per-line start pulse.
- Generalises the single-purpose two-pass feed FSM: configurable pass count, line range, grid size and BRAM read latency.
- Adds consumer early line termination, squashing of in-flight reads, and sticky error/abort.
- Sits between the text-editor BRAM read port and the assembler.

Parameters:
- LINE_WIDTH, 64, characters per line (power of two).
- NUM_LINES, 256, lines in the grid (power of two).
- NUM_PASSES, 2, full scans per run (1..4).
- READ_LATENCY, 2, cycles from rd_en_out/addr_out to valid char_in (1..4).
- CHAR_W, 8, character width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  pulse; begins a run (restarts if busy)
- abort_in  in  1  pulse; consumer error, stops the run
- first_line_in  in  log2(NUM_LINES)  first line scanned, sampled at start
- last_line_in  in  log2(NUM_LINES)  last line scanned, sampled at start
- line_done_in  in  1  consumer ends the current line early
- addr_out  out  log2(LINE_WIDTH*NUM_LINES)  BRAM read address = line*LINE_WIDTH+col
- rd_en_out  out  1  BRAM read enable
- char_in  in  CHAR_W  BRAM read data
- new_line_out  out  1  one-cycle pulse before the first char of each line
- new_char_out  out  1  char_out/col_out valid
- char_out  out  CHAR_W  delivered character
- col_out  out  log2(LINE_WIDTH)  column of char_out
- line_out  out  log2(NUM_LINES)  current line
- pass_out  out  log2(NUM_PASSES) (min 1)  current pass
- busy_out  out  1  run in progress
- done_out  out  1  one-cycle pulse on successful completion
- error_out  out  1  sticky; set by abort

Behaviour:
- Reset:
  - State IDLE; all outputs 0, including error_out.
  - In-flight pipeline cleared.
- States: IDLE, NEW_LINE, SEND, DRAIN, ERROR.
- IDLE + start_in:
  - Latch range; line=first_line_in, pass=0, col=0.
  - busy_out=1, error_out cleared; next state NEW_LINE.
- NEW_LINE:
  - new_line_out=1 for exactly one cycle, no read issued; next state SEND.
- SEND:
  - Each cycle: rd_en_out=1, addr_out for current col, col++.
  - A valid/col shift register of depth READ_LATENCY tags each issue.
  - Tagged data emerges as new_char_out with char_out=char_in and col_out=tag, exactly READ_LATENCY cycles after issue.
  - After issuing col LINE_WIDTH-1, go to DRAIN; in-flight reads are delivered normally.
- line_done_in (SEND or DRAIN):
  - Stop issuing and squash all in-flight tags; no further new_char_out for this line.
  - Next state is DRAIN with an empty pipeline, which lasts 1 cycle.
- DRAIN: wait until the pipeline is empty, then:
  - If line != last: line++, col=0, go to NEW_LINE.
  - Else if pass < NUM_PASSES-1: pass++, line=first, go to NEW_LINE.
  - Else: done_out pulse, busy_out=0, go to IDLE.
- first_line_in > last_line_in at start:
  - No lines scanned; done_out pulses the cycle after start; busy_out high for that 1 cycle.
- abort_in in any busy state:
  - Squash pipeline, error_out=1, busy_out=0, go to ERROR.
  - ERROR is exited only by start_in or rst_in.
- start_in while busy or in ERROR: full restart, same as from IDLE.
- Priority: rst_in > start_in > abort_in > line_done_in.
- line_done_in while idle is ignored.
- Throughput: one char per cycle in SEND.
- Per-line overhead: 1 NEW_LINE cycle plus READ_LATENCY drain cycles on full lines.
- Line and column counters never wrap past their configured range.

Optional Feature:
- Macro: FEED_NUL_TERMINATE_EN.
- Defined:
  - A delivered char equal to 0 acts as an internal line_done: it is not emitted, in-flight tags are squashed, and the FSM goes to DRAIN.
  - This triggers at most once per line.
  - A NUL at col 0 yields a line with only new_line_out.
- Undefined: NUL characters are delivered like any other character.

Test Plan:
- Defaults, first=0, last=1, grid filled so char = col[7:0] -> pass 0 line 0 and line 1, then pass 1 line 0 and line 1. Each line gives 1 new_line_out and 64 new_char_out with char_out=col_out=0..63, in order. Then one done_out.
- READ_LATENCY=3, line_done_in asserted the cycle col 10 is delivered -> no chars with col_out>10 on that line. Next new_line_out arrives ≤ 2 cycles later.
- abort_in during pass 1 line 0 col 5 -> error_out=1, busy_out=0, no further new_char_out. A later start_in clears error_out and restarts at pass 0.
- first=5, last=3 -> no new_line_out; done_out 1 cycle after start_in.
- start_in mid-run at line 2 -> pipeline squashed; next new_line_out reports line_out=first, pass_out=0.
- FEED_NUL_TERMINATE_EN defined, line 0 = "ADD" followed by 0x00 -> exactly 3 new_char_out (0x41,0x44,0x44), then the next line starts.
